// File: rtl/phi_pkg.sv
// Shared types and default sizing for the T-value producer and its solver-side peers.
package phi_pkg;

    localparam int BIT_WIDTH_D = 32;
    localparam int I_D         = 160;
    localparam int FORMANTS_D  = 5;
    localparam int NU_VALUES_D = 3;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_ACCUM,
        TX_START,
        TX_GAP,
        TX_BEAT,
        TX_HOLDOFF
    } tx_state_t;

    typedef logic signed [BIT_WIDTH_D-1:0] tval_t;
    typedef tval_t [NU_VALUES_D-1:0]       tvals_t;

endpackage

// File: rtl/segment_accumulator.sv
// Running per-lag sums over one frame of bins, with snapshots taken at the
// segment-end bins and any uncaptured snapshots filled when the frame ends early.
module segment_accumulator
    import phi_pkg::*;
#(
    parameter  int BIT_WIDTH = BIT_WIDTH_D,
    parameter  int I         = I_D,
    parameter  int FORMANTS  = FORMANTS_D,
    parameter  int NU_VALUES = NU_VALUES_D,
    localparam int IDX_W     = $clog2(I)
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst_n,
    input  logic                                         i_open,
    input  logic                                         i_bin_en,
    input  logic [FORMANTS-1:0][IDX_W-1:0]               i_seg_end,
    input  logic                                         i_bin_valid,
    input  logic [NU_VALUES-1:0][BIT_WIDTH-1:0]          i_bin_data,
    input  logic                                         i_bin_last,
    output logic                                         o_frame_end,
    output logic [FORMANTS-1:0][NU_VALUES-1:0][BIT_WIDTH-1:0] o_store
);

    localparam int K_W = $clog2(FORMANTS + 1);

    logic [FORMANTS-1:0][IDX_W-1:0]                    r_seg;
    logic [NU_VALUES-1:0][BIT_WIDTH-1:0]               r_acc;
    logic [IDX_W-1:0]                                  r_bin;
    logic [K_W-1:0]                                    r_k;
    logic [FORMANTS-1:0][NU_VALUES-1:0][BIT_WIDTH-1:0] r_store;

    logic [FORMANTS-1:0][IDX_W-1:0]      w_seg;
    logic [NU_VALUES-1:0][BIT_WIDTH-1:0] w_acc_base;
    logic [NU_VALUES-1:0][BIT_WIDTH-1:0] w_acc_next;
    logic [IDX_W-1:0]                    w_idx;
    logic [K_W-1:0]                      w_k;
    logic [K_W-1:0]                      w_k_next;
    logic [IDX_W-1:0]                    w_seg_cur;
    logic                                w_accept;
    logic                                w_hit;
    logic                                w_end;

    function automatic logic [BIT_WIDTH-1:0] add_wrap(
        input logic signed [BIT_WIDTH-1:0] a,
        input logic signed [BIT_WIDTH-1:0] b
    );
        return a + b;
    endfunction

    // A frame opened this cycle must see its own bin 0 against zeroed state.
    always_comb begin
        w_seg      = i_open ? i_seg_end : r_seg;
        w_acc_base = i_open ? '0 : r_acc;
        w_idx      = i_open ? '0 : r_bin;
        w_k        = i_open ? '0 : r_k;
        w_accept   = i_bin_en && i_bin_valid;
        for (int n = 0; n < NU_VALUES; n++) begin
            w_acc_next[n] = add_wrap(w_acc_base[n], i_bin_data[n]);
        end
        w_seg_cur = '0;
        for (int f = 0; f < FORMANTS; f++) begin
            if (w_k == K_W'(f)) begin
                w_seg_cur = w_seg[f];
            end
        end
        w_hit    = w_accept && (w_k < K_W'(FORMANTS)) && (w_idx == w_seg_cur);
        w_k_next = w_k + K_W'(w_hit);
        w_end    = w_accept && (i_bin_last || (w_idx == IDX_W'(I - 1)));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg   <= '0;
            r_acc   <= '0;
            r_bin   <= '0;
            r_k     <= '0;
            r_store <= '0;
        end else begin
            if (i_open) begin
                r_seg <= i_seg_end;
            end
            if (w_accept) begin
                r_acc <= w_acc_next;
                r_bin <= w_idx + IDX_W'(1);
                r_k   <= w_k_next;
                for (int f = 0; f < FORMANTS; f++) begin
                    if ((w_hit && (w_k == K_W'(f))) || (w_end && (w_k_next <= K_W'(f)))) begin
                        r_store[f] <= w_acc_next;
                    end
                end
            end else if (i_open) begin
                r_acc <= '0;
                r_bin <= '0;
                r_k   <= '0;
            end
        end
    end

    assign o_frame_end = w_end;
    assign o_store     = r_store;

endmodule

// File: rtl/formant_tvals_tx.sv
// Producer side of the T-value handshake: accumulates one frame of bins, then
// sends a start flare and FORMANTS paced beats of cumulative sums to the phi solver.
module formant_tvals_tx
    import phi_pkg::*;
#(
    parameter  int BIT_WIDTH      = BIT_WIDTH_D,
    parameter  int I              = I_D,
    parameter  int FORMANTS       = FORMANTS_D,
    parameter  int NU_VALUES      = NU_VALUES_D,
    parameter  int GAP_CYCLES     = 1,
    parameter  int HOLDOFF_CYCLES = 700,
    localparam int IDX_W          = $clog2(I)
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                frame_start_in,
    input  logic [FORMANTS-1:0][IDX_W-1:0]      seg_end_in,
    input  logic                                bin_valid_in,
    input  logic [NU_VALUES-1:0][BIT_WIDTH-1:0] bin_data_in,
    input  logic                                bin_last_in,
    output logic [NU_VALUES-1:0][BIT_WIDTH-1:0] T_vals,
    output logic                                output_start,
    output logic                                output_valid,
    output logic                                busy_out,
    output logic                                overrun_out
);

    localparam int BEAT_W  = $clog2(FORMANTS + 1);
    localparam int CNT_MAX = (GAP_CYCLES > HOLDOFF_CYCLES) ? GAP_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    tx_state_t                           r_state;
    logic [CNT_W-1:0]                    r_cnt;
    logic [BEAT_W-1:0]                   r_beat;
    logic                                r_start;
    logic                                r_valid;
    logic                                r_busy;
    logic                                r_overrun;
    logic [NU_VALUES-1:0][BIT_WIDTH-1:0] r_tvals;

    logic                                              w_open;
    logic                                              w_bin_en;
    logic                                              w_frame_end;
    logic [FORMANTS-1:0][NU_VALUES-1:0][BIT_WIDTH-1:0] w_store;
    logic [NU_VALUES-1:0][BIT_WIDTH-1:0]               w_beat_tvals;

    assign w_open   = frame_start_in && ((r_state == TX_IDLE) || (r_state == TX_ACCUM));
    assign w_bin_en = w_open || (r_state == TX_ACCUM);

    segment_accumulator #(
        .BIT_WIDTH (BIT_WIDTH),
        .I         (I),
        .FORMANTS  (FORMANTS),
        .NU_VALUES (NU_VALUES)
    ) u_accum (
        .i_clk       (clk_in),
        .i_rst_n     (rst_in),
        .i_open      (w_open),
        .i_bin_en    (w_bin_en),
        .i_seg_end   (seg_end_in),
        .i_bin_valid (bin_valid_in),
        .i_bin_data  (bin_data_in),
        .i_bin_last  (bin_last_in),
        .o_frame_end (w_frame_end),
        .o_store     (w_store)
    );

    always_comb begin
        w_beat_tvals = '0;
        for (int f = 0; f < FORMANTS; f++) begin
            if (r_beat == BEAT_W'(f)) begin
                w_beat_tvals = w_store[f];
            end
        end
    end

    // Outputs are registered alongside the state they belong to, so the state
    // held during a cycle is exactly what the outputs show in that cycle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state   <= TX_IDLE;
            r_cnt     <= '0;
            r_beat    <= '0;
            r_start   <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_tvals   <= '0;
        end else begin
            r_start   <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= frame_start_in && (r_state != TX_IDLE);
            unique case (r_state)
                TX_IDLE, TX_ACCUM: begin
                    if (w_frame_end) begin
                        r_state <= TX_START;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                    end else if (w_open) begin
                        r_state <= TX_ACCUM;
                        r_busy  <= 1'b1;
                    end
                end
                TX_START: begin
                    r_state <= TX_GAP;
                    r_cnt   <= CNT_W'(GAP_CYCLES - 1);
                    r_beat  <= '0;
                end
                TX_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= TX_BEAT;
                        r_valid <= 1'b1;
                        r_tvals <= w_beat_tvals;
                        r_beat  <= r_beat + BEAT_W'(1);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                TX_BEAT: begin
                    if (r_beat == BEAT_W'(FORMANTS)) begin
                        if (HOLDOFF_CYCLES == 0) begin
                            r_state <= TX_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= TX_HOLDOFF;
                            r_cnt   <= CNT_W'(HOLDOFF_CYCLES - 1);
                        end
                    end else begin
                        r_state <= TX_GAP;
                        r_cnt   <= CNT_W'(GAP_CYCLES - 1);
                    end
                end
                TX_HOLDOFF: begin
                    if (r_cnt == '0) begin
                        r_state <= TX_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= TX_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign T_vals       = r_tvals;
    assign output_start = r_start;
    assign output_valid = r_valid;
    assign busy_out     = r_busy;
    assign overrun_out  = r_overrun;

endmodule

// File: tb/tb_formant_tvals_tx.sv
// Scoreboard bench for formant_tvals_tx: directed frames plus randomized frames
// checked against a prefix-sum reference model.
module tb_formant_tvals_tx;
    import phi_pkg::*;

    localparam int BW   = 32;
    localparam int NI   = 160;
    localparam int NF   = 5;
    localparam int NU   = 3;
    localparam int GAP  = 1;
    localparam int HOLD = 20;
    localparam int IW   = $clog2(NI);

    typedef logic [NF-1:0][IW-1:0] seg_t;
    typedef struct {
        bit     is_start;
        int     at;
        tvals_t t;
    } ev_t;

    logic                 clk_in = 1'b0;
    logic                 rst_in = 1'b0;
    logic                 frame_start_in = 1'b0;
    seg_t                 seg_end_in = '0;
    logic                 bin_valid_in = 1'b0;
    logic [NU-1:0][BW-1:0] bin_data_in = '0;
    logic                 bin_last_in = 1'b0;
    logic [NU-1:0][BW-1:0] T_vals;
    logic                 output_start;
    logic                 output_valid;
    logic                 busy_out;
    logic                 overrun_out;

    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    int     ovr_seen = 0;
    int     exp_ovr = 0;
    int     last_beat = 0;
    ev_t    exp_q[$];
    ev_t    mon_e;
    tvals_t frame_data[NI];

    formant_tvals_tx #(
        .BIT_WIDTH      (BW),
        .I              (NI),
        .FORMANTS       (NF),
        .NU_VALUES      (NU),
        .GAP_CYCLES     (GAP),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .frame_start_in (frame_start_in),
        .seg_end_in     (seg_end_in),
        .bin_valid_in   (bin_valid_in),
        .bin_data_in    (bin_data_in),
        .bin_last_in    (bin_last_in),
        .T_vals         (T_vals),
        .output_start   (output_start),
        .output_valid   (output_valid),
        .busy_out       (busy_out),
        .overrun_out    (overrun_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check_bit(input string name, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_tv(input string name, input tvals_t act, input tvals_t req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk_in) begin
        if (rst_in) begin
            if (overrun_out) ovr_seen++;
            if (output_start || output_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_strobe: got start=%b valid=%b, required none (cycle %0d)",
                             output_start, output_valid, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_bit("start_flag", output_start, mon_e.is_start);
                    check_bit("valid_flag", output_valid, !mon_e.is_start);
                    check_int("strobe_cycle", cyc, mon_e.at);
                    if (!mon_e.is_start) check_tv("T_vals", T_vals, mon_e.t);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic fill_const(input int a, input int b, input int c);
        for (int i = 0; i < NI; i++) begin
            frame_data[i][0] = a;
            frame_data[i][1] = b;
            frame_data[i][2] = c;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NI; i++)
            for (int l = 0; l < NU; l++) frame_data[i][l] = $urandom;
    endtask

    function automatic seg_t rand_seg();
        seg_t s;
        s[0] = IW'($urandom_range(0, 30));
        for (int f = 1; f < NF; f++)
            s[f] = IW'(int'(s[f-1]) + 1 + int'($urandom_range(0, 30)));
        return s;
    endfunction

    // Reference: snapshot f is the prefix sum through min(seg_end[f], last bin).
    task automatic send_frame(input seg_t seg, input int n, input bit use_last,
                              input int abort_at, input bit gaps, input bit exp_restart);
        tvals_t acc;
        tvals_t pre[NI];
        ev_t    e;
        int     nsend;
        int     b;
        int     idx;
        bit     first;
        acc = '0;
        for (int i = 0; i < n; i++) begin
            for (int l = 0; l < NU; l++) acc[l] = acc[l] + frame_data[i][l];
            pre[i] = acc;
        end
        nsend = (abort_at >= 0) ? abort_at : n;
        b = 0;
        first = 1'b1;
        while (b < nsend) begin
            frame_start_in = first;
            for (int f = 0; f < NF; f++) seg_end_in[f] = first ? seg[f] : IW'($urandom);
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                bin_valid_in = 1'b0;
                bin_data_in  = {$urandom, $urandom, $urandom};
                bin_last_in  = 1'($urandom);
            end else begin
                bin_valid_in = 1'b1;
                bin_data_in  = frame_data[b];
                bin_last_in  = use_last && (abort_at < 0) && (b == n - 1);
                if ((abort_at < 0) && (b == n - 1)) begin
                    e.is_start = 1'b1;
                    e.at = cyc + 1;
                    e.t = '0;
                    exp_q.push_back(e);
                    for (int f = 0; f < NF; f++) begin
                        idx = (int'(seg[f]) <= n - 1) ? int'(seg[f]) : n - 1;
                        e.is_start = 1'b0;
                        e.at = cyc + 1 + (f + 1) * (GAP + 1);
                        e.t = pre[idx];
                        exp_q.push_back(e);
                    end
                    last_beat = cyc + 1 + NF * (GAP + 1);
                end
                b++;
            end
            tick();
            if (first) begin
                check_bit("busy_after_frame_start", busy_out, 1'b1);
                if (exp_restart) begin
                    check_bit("overrun_on_restart", overrun_out, 1'b1);
                    exp_ovr++;
                end else begin
                    check_bit("no_overrun_on_open", overrun_out, 1'b0);
                end
            end
            first = 1'b0;
        end
        frame_start_in = 1'b0;
        bin_valid_in   = 1'b0;
        bin_last_in    = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (((exp_q.size() != 0) || busy_out) && (n < 2000)) begin
            bin_valid_in = 1'($urandom);
            bin_last_in  = 1'($urandom);
            bin_data_in  = {$urandom, $urandom, $urandom};
            tick();
            n++;
        end
        bin_valid_in = 1'b0;
        bin_last_in  = 1'b0;
        tests++;
        if ((exp_q.size() != 0) || busy_out) begin
            fails++;
            $display("FAIL frame_completion: got %0d pending strobes busy=%b, required 0 and 0",
                     exp_q.size(), busy_out);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        seg_t std_seg;
        seg_t seg3;
        int   n;
        bit   ul;
        std_seg = {8'd159, 8'd127, 8'd95, 8'd63, 8'd31};
        seg3    = {8'd159, 8'd127, 8'd95, 8'd63, 8'd1};

        #12;
        check_bit("reset_start", output_start, 1'b0);
        check_bit("reset_valid", output_valid, 1'b0);
        check_bit("reset_busy", busy_out, 1'b0);
        check_bit("reset_overrun", overrun_out, 1'b0);
        check_tv("reset_tvals", T_vals, '0);
        @(negedge clk_in);
        rst_in = 1'b1;
        tick();
        tick();

        // Full frame
        fill_const(1, 2, -1);
        send_frame(std_seg, NI, 1'b1, -1, 1'b0, 1'b0);
        wait_until(last_beat + HOLD);
        check_bit("busy_last_holdoff", busy_out, 1'b1);
        tick();
        check_bit("busy_after_holdoff", busy_out, 1'b0);
        check_int("queue_drained_full", exp_q.size(), 0);

        // Early last at bin 40
        send_frame(std_seg, 41, 1'b1, -1, 1'b0, 1'b0);
        wait_done();

        // Wrapping accumulation
        fill_const(0, 0, 0);
        frame_data[0][0] = 32'h7FFF_FFFF;
        frame_data[1][0] = 32'h7FFF_FFFF;
        send_frame(seg3, 2, 1'b1, -1, 1'b0, 1'b0);
        wait_done();

        // frame_start during HOLDOFF
        fill_const(1, 2, -1);
        send_frame(std_seg, 41, 1'b1, -1, 1'b0, 1'b0);
        wait_until(last_beat + 5);
        frame_start_in = 1'b1;
        bin_valid_in   = 1'b1;
        tick();
        frame_start_in = 1'b0;
        bin_valid_in   = 1'b0;
        check_bit("overrun_in_holdoff", overrun_out, 1'b1);
        exp_ovr++;
        wait_until(last_beat + HOLD);
        check_bit("busy_holdoff_kept", busy_out, 1'b1);
        tick();
        check_bit("idle_on_schedule", busy_out, 1'b0);
        fill_rand();
        send_frame(rand_seg(), NI, 1'b0, -1, 1'b1, 1'b0);
        wait_done();

        // frame_start during ACCUM at bin 50
        fill_const(1, 2, -1);
        send_frame(std_seg, NI, 1'b1, 50, 1'b0, 1'b0);
        fill_rand();
        send_frame(std_seg, NI, 1'b1, -1, 1'b0, 1'b1);
        wait_done();

        // Reset after beat 2
        fill_const(3, -4, 5);
        send_frame(std_seg, NI, 1'b1, -1, 1'b0, 1'b0);
        n = 0;
        while ((exp_q.size() > 2) && (n < 200)) begin
            tick();
            n++;
        end
        check_int("pending_before_reset", exp_q.size(), 2);
        #2;
        rst_in = 1'b0;
        #1;
        check_bit("async_reset_start", output_start, 1'b0);
        check_bit("async_reset_valid", output_valid, 1'b0);
        check_bit("async_reset_busy", busy_out, 1'b0);
        check_bit("async_reset_overrun", overrun_out, 1'b0);
        check_tv("async_reset_tvals", T_vals, '0);
        exp_q.delete();
        repeat (3) tick();
        #2;
        rst_in = 1'b1;
        repeat (40) tick();
        fill_rand();
        send_frame(rand_seg(), NI, 1'b1, -1, 1'b1, 1'b0);
        wait_done();

        // Randomized frames
        repeat (6) begin
            fill_rand();
            ul = 1'($urandom);
            n  = ul ? int'($urandom_range(1, NI)) : NI;
            send_frame(rand_seg(), n, ul, -1, 1'b1, 1'b0);
            wait_done();
        end

        check_int("expected_queue_empty", exp_q.size(), 0);
        check_int("overrun_count", ovr_seen, exp_ovr);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
